// File: rtl/filter_history_pkg.sv
`default_nettype none
// ============================================================================
// Module   : filter_history_pkg
// Brief    : Shared types and constants for the TX transition history and the
//            downstream per-slot pwl step-response sum.
// Revision : 1.0 - initial release
// ============================================================================
package filter_history_pkg;

    // Geometry of the pwl step-response tables; a transition older than the
    // table span contributes nothing further and is expired.
    localparam int FILTER_ADDR_WIDTH    = 5;
    localparam int FILTER_SEGMENT_WIDTH = 3;

    // Elapsed-time format (fixed point, raw LSBs). Must be wide enough to hold
    // HIST_DT_MAX itself, since an expired slot parks its dt at the limit.
    localparam int HIST_DT_WIDTH = 12;
    localparam int HIST_DEPTH    = 4;
    localparam int HIST_DT_MAX   = 1 << (FILTER_ADDR_WIDTH + FILTER_SEGMENT_WIDTH);

    typedef logic [HIST_DT_WIDTH-1:0] HIST_DT_FORMAT;

    typedef struct packed {
        HIST_DT_FORMAT dt;
        logic          pol;
        logic          valid;
    } hist_slot_t;

    // Unsigned add evaluated one bit wider than the operands, clamped at limit.
    function automatic HIST_DT_FORMAT hist_sat_add(input HIST_DT_FORMAT dt,
                                                   input HIST_DT_FORMAT step,
                                                   input HIST_DT_FORMAT limit);
        logic [HIST_DT_WIDTH:0] sum;
        sum = {1'b0, dt} + {1'b0, step};
        if (sum >= {1'b0, limit})
            return limit;
        return sum[HIST_DT_WIDTH-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/filter_history_slot.sv
`default_nettype none
// ============================================================================
// Module   : filter_history_slot
// Brief    : One transition-history slot: saturating ageing, expiry at the
//            limit, and shift-load from the neighbouring (newer) slot.
// Revision : 1.0 - initial release
// ============================================================================
module filter_history_slot
    import filter_history_pkg::*;
#(
    parameter int DT_MAX = HIST_DT_MAX
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_age_en,
    input  logic                     i_shift_en,
    input  hist_slot_t               i_shift_in,
    input  logic [HIST_DT_WIDTH-1:0] i_dt_step,
    output hist_slot_t               o_slot_q,
    output hist_slot_t               o_aged,
    output hist_slot_t               o_slot_next
);

    localparam HIST_DT_FORMAT c_DT_MAX = HIST_DT_FORMAT'(DT_MAX);

    hist_slot_t r_slot;

    // Aged view of this slot; invalid slots stay frozen so expired dt sits at the limit.
    always_comb begin
        o_aged = r_slot;
        if (i_age_en && r_slot.valid) begin
            o_aged.dt    = hist_sat_add(r_slot.dt, i_dt_step, c_DT_MAX);
            o_aged.valid = (o_aged.dt != c_DT_MAX);
        end
    end

    // Next state: a shift takes the newer slot's aged value, otherwise keep own aged value.
    always_comb begin
        o_slot_next = i_shift_en ? i_shift_in : o_aged;
    end

    // Slot register.
    always_ff @(posedge clk) begin
        if (rst)
            r_slot <= '0;
        else
            r_slot <= o_slot_next;
    end

    assign o_slot_q = r_slot;

endmodule
`default_nettype wire

// File: rtl/filter_history.sv
`default_nettype none
// ============================================================================
// Module   : filter_history
// Brief    : Tracks the most recent TX symbol transitions and reports, per
//            slot (slot 0 = newest), elapsed emulated time and polarity for
//            the downstream pwl step-response instances.
//            Optional macro FILTER_HIST_OVF_CNT_EN adds a saturating counter
//            of still-valid transitions pushed out of the oldest slot.
// Revision : 1.0 - initial release
// ============================================================================
module filter_history
    import filter_history_pkg::*;
#(
    parameter int N_HIST    = HIST_DEPTH,
    parameter int DT_MAX    = HIST_DT_MAX,
    parameter int CNT_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cke,
    input  logic [HIST_DT_WIDTH-1:0]          dt_step,
    input  logic                              edge_val,
    input  logic                              edge_valid,
    output logic [N_HIST*HIST_DT_WIDTH-1:0]   hist_dt,
    output logic [N_HIST-1:0]                 hist_pol,
    output logic [N_HIST-1:0]                 hist_valid,
    output logic [$clog2(N_HIST+1)-1:0]       hist_count,
    output logic [CNT_WIDTH-1:0]              ovf_count
);

    localparam int c_CW = $clog2(N_HIST + 1);

    hist_slot_t       w_q        [N_HIST];
    hist_slot_t       w_aged     [N_HIST];
    hist_slot_t       w_next     [N_HIST];
    hist_slot_t       w_shift_in [N_HIST];
    logic             w_transition;
    logic [c_CW-1:0]  w_next_count;
    logic [c_CW-1:0]  r_count;
    logic             r_last_val;

    // A transition is a meaningful symbol that differs from the last accepted one.
    assign w_transition = cke & edge_valid & (edge_val != r_last_val);

    generate
        for (genvar k = 0; k < N_HIST; k++) begin : g_slot
            if (k == 0) begin : g_head
                assign w_shift_in[k] = '{dt: HIST_DT_FORMAT'(0), pol: edge_val, valid: 1'b1};
            end else begin : g_tail
                assign w_shift_in[k] = w_aged[k-1];
            end

            filter_history_slot #(
                .DT_MAX (DT_MAX)
            ) u_slot (
                .clk         (clk),
                .rst         (rst),
                .i_age_en    (cke),
                .i_shift_en  (w_transition),
                .i_shift_in  (w_shift_in[k]),
                .i_dt_step   (dt_step),
                .o_slot_q    (w_q[k]),
                .o_aged      (w_aged[k]),
                .o_slot_next (w_next[k])
            );

            assign hist_dt[k*HIST_DT_WIDTH +: HIST_DT_WIDTH] = w_q[k].dt;
            assign hist_pol[k]                               = w_q[k].pol;
            assign hist_valid[k]                             = w_q[k].valid;
        end
    endgenerate

    // Population count of next-cycle valid flags so the count registers with the slots.
    always_comb begin
        w_next_count = '0;
        for (int i = 0; i < N_HIST; i++)
            w_next_count = w_next_count + c_CW'(w_next[i].valid);
    end

    // Valid-slot count register.
    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else
            r_count <= w_next_count;
    end

    assign hist_count = r_count;

    // Last accepted symbol value; resets to -1 so a first +1 counts as rising.
    always_ff @(posedge clk) begin
        if (rst)
            r_last_val <= 1'b0;
        else if (w_transition)
            r_last_val <= edge_val;
    end

`ifdef FILTER_HIST_OVF_CNT_EN
    logic                 w_drop;
    logic [CNT_WIDTH-1:0] r_ovf;

    // Oldest slot still valid after ageing is lost when the history shifts.
    assign w_drop = w_transition & w_aged[N_HIST-1].valid;

    // Saturating count of dropped valid transitions.
    always_ff @(posedge clk) begin
        if (rst)
            r_ovf <= '0;
        else if (w_drop && (r_ovf != {CNT_WIDTH{1'b1}}))
            r_ovf <= r_ovf + 1'b1;
    end

    assign ovf_count = r_ovf;
`else
    assign ovf_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_filter_history.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_history
// Brief    : Self-checking bench for filter_history against a queue-based
//            reference model of the transition history.
// Revision : 1.0 - initial release
// ============================================================================
module tb_filter_history;
    import filter_history_pkg::*;

    localparam int N   = 4;
    localparam int DTM = 100;
    localparam int CW  = 16;
    localparam int DW  = HIST_DT_WIDTH;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cke;
    logic [DW-1:0]        dt_step;
    logic                 edge_val;
    logic                 edge_valid;
    logic [N*DW-1:0]      hist_dt;
    logic [N-1:0]         hist_pol;
    logic [N-1:0]         hist_valid;
    logic [$clog2(N+1)-1:0] hist_count;
    logic [CW-1:0]        ovf_count;

    filter_history #(
        .N_HIST    (N),
        .DT_MAX    (DTM),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cke        (cke),
        .dt_step    (dt_step),
        .edge_val   (edge_val),
        .edge_valid (edge_valid),
        .hist_dt    (hist_dt),
        .hist_pol   (hist_pol),
        .hist_valid (hist_valid),
        .hist_count (hist_count),
        .ovf_count  (ovf_count)
    );

    always #5 clk = ~clk;

    // Reference model: newest transition at the front of the queue.
    typedef struct {
        int dt;
        bit pol;
        bit valid;
    } ent_t;

    ent_t mq[$];
    bit   m_last;
    int   m_ovf;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < N; i++) mq.push_back('{dt: 0, pol: 1'b0, valid: 1'b0});
        m_last = 1'b0;
        m_ovf  = 0;
    endtask

    task automatic model_step(input bit r, input bit c, input int s, input bit ev, input bit evv);
        ent_t e;
        if (r) begin
            model_reset();
        end else if (c) begin
            for (int k = 0; k < N; k++) begin
                e = mq[k];
                if (e.valid) begin
                    e.dt = (e.dt + s >= DTM) ? DTM : e.dt + s;
                    if (e.dt == DTM) e.valid = 1'b0;
                end
                mq[k] = e;
            end
            if (evv && (ev != m_last)) begin
                if (mq[N-1].valid && m_ovf < 65535) m_ovf++;
                void'(mq.pop_back());
                mq.push_front('{dt: 0, pol: ev, valid: 1'b1});
                m_last = ev;
            end
        end
    endtask

    function automatic int exp_ovf();
`ifdef FILTER_HIST_OVF_CNT_EN
        return m_ovf;
`else
        return 0;
`endif
    endfunction

    task automatic check_all();
        int cnt;
        cnt = 0;
        for (int k = 0; k < N; k++) begin
            check_val($sformatf("dt[%0d]", k), 32'(hist_dt[k*DW +: DW]), mq[k].dt);
            check_val($sformatf("pol[%0d]", k), 32'(hist_pol[k]), 32'(mq[k].pol));
            check_val($sformatf("valid[%0d]", k), 32'(hist_valid[k]), 32'(mq[k].valid));
            if (mq[k].valid) cnt++;
        end
        check_val("count", 32'(hist_count), cnt);
        check_val("ovf", 32'(ovf_count), exp_ovf());
    endtask

    // Apply one cycle of inputs, advance the model, then compare away from the edge.
    task automatic cyc(input bit r, input bit c, input int s, input bit ev, input bit evv);
        rst        = r;
        cke        = c;
        dt_step    = s[DW-1:0];
        edge_val   = ev;
        edge_valid = evv;
        @(posedge clk);
        model_step(r, c, s, ev, evv);
        #1;
        check_all();
    endtask

    initial begin
        int s;
        bit ev;
        model_reset();

        // 1: reset held three cycles
        for (int i = 0; i < 3; i++) cyc(1, 1, 10, 1, 1);
        check_val("t1_valid", 32'(hist_valid), 0);
        check_val("t1_count", 32'(hist_count), 0);

        // 2: rising transition then three steps of ageing
        cyc(0, 1, 10, 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 10, 0, 0);
        check_val("t2_dt0", 32'(hist_dt[DW-1:0]), 30);
        check_val("t2_pol0", 32'(hist_pol[0]), 1);
        check_val("t2_count", 32'(hist_count), 1);

        // 3: same value again is not a transition
        cyc(0, 1, 10, 1, 1);
        check_val("t3_dt0", 32'(hist_dt[DW-1:0]), 40);
        check_val("t3_count", 32'(hist_count), 1);

        // cke low holds everything and ignores the edge
        cyc(0, 0, 50, 0, 1);
        check_val("hold_dt0", 32'(hist_dt[DW-1:0]), 40);

        // 4: five alternating transitions from a clean start
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 10, (i % 2) == 0, 1);
        check_val("t4_count", 32'(hist_count), 4);
        check_val("t4_dt3", 32'(hist_dt[3*DW +: DW]), 30);
        cyc(0, 1, 10, 1, 1);
`ifdef FILTER_HIST_OVF_CNT_EN
        check_val("t4_ovf", 32'(ovf_count), 1);
`else
        check_val("t4_ovf", 32'(ovf_count), 0);
`endif

        // 5: saturation and expiry, then an edge in the expiry step
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 10, 1, 1);
        cyc(0, 1, 60, 0, 0);
        cyc(0, 1, 60, 0, 0);
        check_val("t5_dt0", 32'(hist_dt[DW-1:0]), 100);
        check_val("t5_count", 32'(hist_count), 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 10, 1, 1);
        cyc(0, 1, 60, 0, 0);
        cyc(0, 1, 60, 0, 1);
        check_val("t5_dt1", 32'(hist_dt[DW +: DW]), 100);
        check_val("t5_valid", 32'(hist_valid), 1);

        // 6: reset mid-stream wins over a simultaneous transition
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 10, (i % 2) == 0, 1);
        check_val("t6_count3", 32'(hist_count), 3);
        cyc(1, 1, 10, 0, 1);
        check_val("t6_cleared", 32'(hist_valid), 0);
        cyc(0, 1, 10, 1, 1);
        check_val("t6_rise", 32'(hist_valid), 1);

        // Randomized stream
        for (int i = 0; i < 600; i++) begin
            s  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 40);
            ev = 1'($urandom_range(0, 1));
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, s, ev,
                $urandom_range(0, 9) < 7);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
